type1_table_writer: RTL and testbench

TYPE1_TABLE_WRITER -- requirements
Module: type1_table_writer

---
 rtl/type1_table_writer_if.sv | 44 ++++
 rtl/type1_table_writer.sv | 159 +++++++++++++++
 tb/tb_type1_table_writer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/type1_table_writer_if.sv
// Host request/response and rule-table RAM port bundle for type1_table_writer.
// The writer block connects through the slave modport; the host/RAM side uses master.
interface type1_table_writer_if #(
  parameter int ADDR_W  = 11,
  parameter int FIELD_W = 12,
  parameter int ERR_W   = 8
);
  // Host requests
  logic                   wr_req;
  logic [ADDR_W-1:0]      wr_addr;
  logic [FIELD_W-1:0]     wr_depth;
  logic [FIELD_W-1:0]     wr_offset;
  logic                   rd_req;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   clear_req;
  // Host responses
  logic                   req_ready;
  logic                   wr_done;
  logic                   wr_err;
  logic                   rd_valid;
  logic [2*FIELD_W-1:0]   rd_data;
  logic                   clear_done;
  logic                   busy;
  logic [ERR_W-1:0]       err_count;
  // Rule-table RAM port
  logic [ADDR_W-1:0]      ram_addr;
  logic [2*FIELD_W-1:0]   ram_din;
  logic                   ram_we;
  logic [2*FIELD_W-1:0]   ram_dout;

  modport slave (
    input  wr_req, wr_addr, wr_depth, wr_offset, rd_req, rd_addr, clear_req,
    input  ram_dout,
    output req_ready, wr_done, wr_err, rd_valid, rd_data, clear_done, busy,
    output err_count, ram_addr, ram_din, ram_we
  );

  modport master (
    output wr_req, wr_addr, wr_depth, wr_offset, rd_req, rd_addr, clear_req,
    output ram_dout,
    input  req_ready, wr_done, wr_err, rd_valid, rd_data, clear_done, busy,
    input  err_count, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/type1_table_writer.sv
// Rule-table writer: single-entry writes with depth/offset validation,
// read-back through a 1-cycle registered RAM, and a full-table clear sweep.
// All RAM/pulse outputs decode from the FSM state, so an asynchronous reset
// drops them immediately.
module type1_table_writer #(
  parameter int ADDR_W  = 11,
  parameter int FIELD_W = 12,
  parameter int ERR_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  type1_table_writer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_READ_WAIT,
    S_CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    clr_q, clr_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [2*FIELD_W-1:0] rdh_q, rdh_d;

  logic [ADDR_W-1:0]    addr_q;
  logic [FIELD_W-1:0]   depth_q;
  logic [FIELD_W-1:0]   offset_q;

  logic                 cap_en;
  logic                 entry_ok;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [2*FIELD_W-1:0] ram_din;
  logic                 wr_done;
  logic                 wr_err;
  logic                 rd_valid;
  logic                 clear_done;
  logic                 ready;

  // Saturating increment for the rejected-write counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == '1) r = v;
    else         r = v + 1'b1;
    return r;
  endfunction

  // Offsets equal to the depth are legal; both fields are plain unsigned.
  assign entry_ok = (offset_q <= depth_q);

  // Control state: FSM, clear sweep counter, error counter, read-back hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      clr_q   <= '0;
      err_q   <= '0;
      rdh_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
      rdh_q   <= rdh_d;
    end
  end

  // Request fields are captured on every IDLE cycle; only the accepted one is used.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      addr_q   <= bus.wr_req ? bus.wr_addr : bus.rd_addr;
      depth_q  <= bus.wr_depth;
      offset_q <= bus.wr_offset;
    end
  end

  // Next-state, RAM port and pulse decode; clear has priority over write over read.
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    err_d      = err_q;
    rdh_d      = rdh_q;
    cap_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    wr_done    = 1'b0;
    wr_err     = 1'b0;
    rd_valid   = 1'b0;
    clear_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        cap_en = 1'b1;
        if (bus.clear_req) begin
          state_d = S_CLEAR;
          clr_d   = '0;
        end else if (bus.wr_req) begin
          state_d = S_WRITE;
        end else if (bus.rd_req) begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        ram_addr = addr_q;
        if (entry_ok) begin
          ram_we  = 1'b1;
          ram_din = {depth_q, offset_q};
          wr_done = 1'b1;
        end else begin
          wr_err = 1'b1;
          err_d  = sat_inc(err_q);
        end
        state_d = S_IDLE;
      end
      S_READ: begin
        ram_addr = addr_q;
        state_d  = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        ram_addr = addr_q;
        rd_valid = 1'b1;
        rdh_d    = bus.ram_dout;
        state_d  = S_IDLE;
      end
      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_q;
        // The sweep ends on the all-ones address; the counter never wraps.
        if (clr_q == ADDR_LAST) begin
          clear_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Not ready while reset is held even though the state already reads IDLE.
  assign ready          = (state_q == S_IDLE) && !reset;
  assign bus.req_ready  = ready;
  assign bus.busy       = !ready;
  assign bus.wr_done    = wr_done;
  assign bus.wr_err     = wr_err;
  assign bus.rd_valid   = rd_valid;
  assign bus.rd_data    = rd_valid ? bus.ram_dout : rdh_q;
  assign bus.clear_done = clear_done;
  assign bus.err_count  = err_q;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_din    = ram_din;
  assign bus.ram_we     = ram_we;

endmodule

// File: tb/tb_type1_table_writer.sv
// Bench for type1_table_writer: registered RAM model plus an entry-level
// table/error-count reference, directed corner cases and random traffic.
module tb_type1_table_writer;

  localparam int AW = 11;
  localparam int FW = 12;
  localparam int EW = 8;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  type1_table_writer_if #(.ADDR_W(AW), .FIELD_W(FW), .ERR_W(EW)) bus ();

  type1_table_writer #(.ADDR_W(AW), .FIELD_W(FW), .ERR_W(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Rule-table RAM with 1-cycle registered read.
  logic [2*FW-1:0] mem [0:N-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  logic [2*FW-1:0] exp_mem [0:N-1];
  int exp_err;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [FW-1:0] d, input logic [FW-1:0] o);
    if (o <= d) exp_mem[a] = {d, o};
    else if (exp_err < (1 << EW) - 1) exp_err++;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [FW-1:0] d, input logic [FW-1:0] o);
    logic ok;
    ok = (o <= d);
    chk("wr_ready", {63'd0, bus.req_ready}, 64'd1);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_depth = d; bus.wr_offset = o;
    step();
    if (ok)
      chk("wr_ok", {bus.ram_we, bus.ram_addr, bus.ram_din, bus.wr_done, bus.wr_err, bus.busy},
          {1'b1, a, d, o, 1'b1, 1'b0, 1'b1});
    else
      chk("wr_bad", {bus.ram_we, bus.wr_done, bus.wr_err, bus.busy}, {1'b0, 1'b0, 1'b1, 1'b1});
    model_write(a, d, o);
    // A read request while busy must be dropped.
    bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = AW'($urandom);
    step();
    bus.rd_req = 1'b0;
    chk("wr_after", {bus.req_ready, bus.err_count, bus.wr_done, bus.wr_err},
        {1'b1, EW'(exp_err), 1'b0, 1'b0});
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    logic [2*FW-1:0] e;
    e = exp_mem[a];
    bus.rd_req = 1'b1; bus.rd_addr = a;
    step();
    chk("rd_issue", {bus.ram_we, bus.ram_addr, bus.rd_valid, bus.busy}, {1'b0, a, 1'b0, 1'b1});
    bus.rd_req = 1'b0;
    step();
    chk("rd_data", {bus.rd_valid, bus.rd_data}, {1'b1, e});
    step();
    chk("rd_hold", {bus.req_ready, bus.rd_valid, bus.rd_data}, {1'b1, 1'b0, e});
  endtask

  task automatic do_clear(input bit all_reqs, input bit hold_wr,
                          input logic [AW-1:0] a, input logic [FW-1:0] d, input logic [FW-1:0] o);
    int pulses;
    bus.clear_req = 1'b1; bus.wr_req = all_reqs | hold_wr; bus.rd_req = all_reqs;
    bus.wr_addr = a; bus.wr_depth = d; bus.wr_offset = o; bus.rd_addr = a;
    step();
    bus.clear_req = 1'b0; bus.rd_req = 1'b0; bus.wr_req = hold_wr;
    for (int i = 0; i < N; i++) begin
      logic [AW-1:0] ai;
      logic last;
      ai = AW'(i);
      last = (i == N - 1);
      chk("clear", {bus.ram_we, bus.ram_addr, bus.ram_din, bus.clear_done, bus.req_ready,
                    bus.busy, bus.wr_done, bus.rd_valid},
          {1'b1, ai, {2*FW{1'b0}}, last, 1'b0, 1'b1, 1'b0, 1'b0});
      exp_mem[i] = '0;
      step();
    end
    chk("clear_end", {bus.req_ready, bus.busy, bus.ram_we, bus.clear_done}, {1'b1, 1'b0, 1'b0, 1'b0});
    if (hold_wr) begin
      step();
      chk("held_wr", {bus.wr_done, bus.ram_we, bus.ram_addr, bus.ram_din}, {1'b1, 1'b1, a, d, o});
      model_write(a, d, o);
      bus.wr_req = 1'b0;
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      pulses = pulses + int'(bus.wr_done) + int'(bus.rd_valid) + int'(bus.ram_we);
    end
    chk("clear_no_extra", 64'(pulses), 64'd0);
  endtask

  initial begin
    int wes;
    reset = 1'b0;
    exp_err = 0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_depth = '0; bus.wr_offset = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.clear_req = 1'b0;

    // Reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_state", {bus.req_ready, bus.busy, bus.ram_we, bus.ram_addr, bus.ram_din, bus.rd_data,
                      bus.err_count, bus.wr_done, bus.wr_err, bus.rd_valid, bus.clear_done},
        {1'b0, 1'b1, 1'b0, {AW{1'b0}}, {2*FW{1'b0}}, {2*FW{1'b0}}, {EW{1'b0}}, 4'b0000});
    step();
    step();
    chk("rst_held", {bus.req_ready, bus.busy, bus.ram_we}, {1'b0, 1'b1, 1'b0});
    reset = 1'b0;
    step();
    chk("rst_release", {bus.req_ready, bus.busy}, {1'b1, 1'b0});

    // Clear with all three requests at once: only the clear runs.
    do_clear(1'b1, 1'b0, 11'd33, 12'd5, 12'd1);

    // Basic write then read-back.
    do_write(11'd5, 12'd100, 12'd20);
    do_read(11'd5);

    // One rejected write.
    do_write(11'd9, 12'd10, 12'd11);
    do_read(11'd9);

    // Comparison boundaries (unsigned, equality legal).
    do_write(11'd0, 12'h000, 12'h000);
    do_write(11'd1, 12'hFFF, 12'hFFF);
    do_write(11'd2, 12'h000, 12'hFFF);
    do_write(11'd3, 12'h800, 12'h7FF);
    do_write(11'd4, 12'h7FF, 12'h800);
    do_write(11'd6, 12'd10,  12'd10);
    do_read(11'd0); do_read(11'd1); do_read(11'd2);
    do_read(11'd3); do_read(11'd4); do_read(11'd6);

    // Random traffic against the table model.
    for (int r = 0; r < 150; r++) begin
      logic [FW-1:0] d, o;
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("idle", {bus.ram_we, bus.ram_addr, bus.ram_din, bus.wr_done, bus.wr_err,
                     bus.rd_valid, bus.clear_done, bus.req_ready},
            {1'b0, {AW{1'b0}}, {2*FW{1'b0}}, 4'b0000, 1'b1});
      end
      if ($urandom_range(0, 2) < 2) begin
        d = FW'($urandom);
        o = ($urandom_range(0, 3) == 0) ? d : FW'($urandom);
        do_write(AW'($urandom_range(0, 15)), d, o);
      end else begin
        do_read(AW'($urandom_range(0, 15)));
      end
    end

    // Error counter saturation.
    for (int s = 0; s < 300; s++) do_write(11'd3, 12'd10, 12'd11);
    chk("err_sat", {56'd0, bus.err_count}, 64'd255);

    // Reset in the middle of a clear sweep.
    do_write(11'd1000, 12'hABC, 12'h0AB);
    do_write(11'd1500, 12'hFFF, 12'h001);
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      exp_mem[i] = '0;
      step();
    end
    chk("clr_at1000", {bus.ram_we, bus.ram_addr}, {1'b1, 11'd1000});
    #2 reset = 1'b1;
    exp_err = 0;
    #1;
    chk("rst_async", {bus.ram_we, bus.ram_addr, bus.ram_din, bus.req_ready, bus.busy,
                      bus.clear_done, bus.err_count, bus.rd_data},
        {1'b0, {AW{1'b0}}, {2*FW{1'b0}}, 1'b0, 1'b1, 1'b0, {EW{1'b0}}, {2*FW{1'b0}}});
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    wes = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      wes = wes + int'(bus.ram_we) + int'(bus.busy);
    end
    chk("no_resume", 64'(wes), 64'd0);
    do_write(11'd0, 12'h123, 12'h045);
    do_read(11'd0);
    do_read(11'd999);
    do_read(11'd1000);
    do_read(11'd1500);

    // Write request held across a clear is taken once on the first IDLE cycle.
    do_clear(1'b0, 1'b1, 11'd7, 12'd200, 12'd200);
    do_read(11'd7);
    do_read(11'd1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
